fetch_4way: RTL and testbench

FETCH_4WAY -- requirements
Module: fetch_4way

---
 rtl/fetch_4way_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 77 +++++++
 rtl/fetch_4way.sv | 108 ++++++++++
 tb/tb_fetch_4way.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_4way_pkg.sv
// Shared widths and the fetch entry record for the 4-thread fetch stage.
package fetch_4way_pkg;
  localparam int PC_W     = 14;
  localparam int TID_W    = 2;
  localparam int INSTR_W  = 32;
  localparam int NTHREADS = 4;
  localparam int IADDR_W  = PC_W - 2;

  typedef struct packed {
    logic               valid;
    logic               dead;
    logic [TID_W-1:0]   tid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus optional skid entry (FETCH_SKID_EN) feeding decode.
// Entries whose tid matches kill_tid are dropped in the kill cycle, and the
// presented out_valid is gated the same cycle so no handshake can take them.
module fetch_skid_buf import fetch_4way_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  entry_t             in_ent,
  input  logic               kill,
  input  logic [TID_W-1:0]   kill_tid,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [TID_W-1:0]   out_tid,
  output logic               skid_v
);
  entry_t out_q, out_d;
  logic   out_free;

  assign out_valid = out_q.valid && !(kill && out_q.tid == kill_tid);
  assign out_free  = !out_valid || out_ready;
  assign out_instr = out_q.instr;
  assign out_pc    = out_q.pc;
  assign out_tid   = out_q.tid;

`ifdef FETCH_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_live;

  assign skid_live = skid_q.valid && !(kill && skid_q.tid == kill_tid);
  assign skid_v    = skid_q.valid;

  // Skid drains into the output register ahead of newer returning data.
  always_comb begin
    out_d        = out_q;
    out_d.valid  = out_valid;
    skid_d       = skid_q;
    skid_d.valid = skid_live;
    if (out_free) begin
      if (skid_live) begin
        out_d  = skid_q;
        skid_d = in_ent;
      end else if (in_ent.valid) begin
        out_d = in_ent;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (in_ent.valid) begin
      skid_d = in_ent;
    end
  end

  // Skid entry register.
  always_ff @(posedge clk) begin
    if (rst) skid_q <= '0;
    else     skid_q <= skid_d;
  end
`else
  assign skid_v = 1'b0;

  // Single output register: load when empty or being drained.
  always_comb begin
    out_d       = out_q;
    out_d.valid = out_valid;
    if (out_free) begin
      if (in_ent.valid) out_d = in_ent;
      else              out_d.valid = 1'b0;
    end
  end
`endif

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end
endmodule

// File: rtl/fetch_4way.sv
// 4-thread instruction fetch: issues one imem read per accepted slot, tags
// it with {pc, tid}, handles execute redirects (pending register + kill by
// tid) and hands live data to decode through fetch_skid_buf.
// Build option: FETCH_SKID_EN adds the skid entry for 1 instruction/cycle.
module fetch_4way import fetch_4way_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic [TID_W-1:0]   tid_in,
  input  logic [PC_W-1:0]    ins_ptr,
  output logic               ip_en,
  output logic               ip_branch,
  output logic [TID_W-1:0]   ip_br_tid,
  output logic [PC_W-1:0]    ip_br_addr,
  input  logic               branch,
  input  logic [TID_W-1:0]   br_tid,
  input  logic [PC_W-1:0]    br_addr,
  output logic               imem_rd,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [TID_W-1:0]   out_tid,
  input  logic               out_ready
);
  logic             infl_v, infl_dead;
  logic [TID_W-1:0] infl_tid;
  logic [PC_W-1:0]  infl_pc;
  logic             pend_v;
  logic [TID_W-1:0] pend_tid;
  logic [PC_W-1:0]  pend_addr;
  logic             can_issue, issue, skid_v;
  entry_t           ret_ent;

`ifdef FETCH_SKID_EN
  logic [1:0] occ;
  // In-flight read counts as held: it lands next cycle with nowhere else to go.
  assign occ       = 2'(out_valid) + 2'(skid_v) + 2'(infl_v) - 2'(out_valid && out_ready);
  assign can_issue = occ < 2'd2;
`else
  // skid_v is tied low in this build; kept in the term so the port is consumed.
  assign can_issue = !infl_v && !skid_v && (!out_valid || out_ready);
`endif

  assign issue      = !rst && fetch_en && can_issue;
  assign imem_rd    = issue;
  assign ip_en      = issue;
  assign imem_addr  = ins_ptr[PC_W-1:2];
  assign ip_branch  = pend_v;
  assign ip_br_tid  = pend_tid;
  assign ip_br_addr = pend_addr;

  // Returning read: live unless tagged dead or killed by this cycle's branch.
  always_comb begin
    ret_ent       = '0;
    ret_ent.valid = infl_v && !infl_dead && !(branch && br_tid == infl_tid);
    ret_ent.tid   = infl_tid;
    ret_ent.pc    = infl_pc;
    ret_ent.instr = imem_rdata;
  end

  // In-flight tag; reads always return the next cycle, so it lives one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_v    <= 1'b0;
      infl_dead <= 1'b0;
      infl_tid  <= '0;
      infl_pc   <= '0;
    end else begin
      infl_v <= issue;
      if (issue) begin
        infl_dead <= (pend_v && tid_in == pend_tid) || (branch && tid_in == br_tid);
        infl_tid  <= tid_in;
        infl_pc   <= ins_ptr;
      end
    end
  end

  // Pending redirect: newest branch wins; consumed by the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v    <= 1'b0;
      pend_tid  <= '0;
      pend_addr <= '0;
    end else if (branch) begin
      pend_v    <= 1'b1;
      pend_tid  <= br_tid;
      pend_addr <= br_addr;
    end else if (issue) begin
      pend_v    <= 1'b0;
    end
  end

  fetch_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_ent    (ret_ent),
    .kill      (branch),
    .kill_tid  (br_tid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_tid   (out_tid),
    .skid_v    (skid_v)
  );
endmodule

// File: tb/tb_fetch_4way.sv
// Directed bench for fetch_4way; expectations adapt to FETCH_SKID_EN.
module tb_fetch_4way;
  logic        clk = 1'b0, rst = 1'b1;
  logic        fetch_en = 1'b0, branch = 1'b0, out_ready = 1'b0;
  logic [1:0]  tid_in = '0, br_tid = '0;
  logic [13:0] ins_ptr = '0, br_addr = '0;
  logic        ip_en, ip_branch, imem_rd, out_valid;
  logic [1:0]  ip_br_tid, out_tid;
  logic [13:0] ip_br_addr, out_pc;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0, out_instr;
  int nvec = 0, nbad = 0;

`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  fetch_4way dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .tid_in(tid_in), .ins_ptr(ins_ptr),
    .ip_en(ip_en), .ip_branch(ip_branch), .ip_br_tid(ip_br_tid), .ip_br_addr(ip_br_addr),
    .branch(branch), .br_tid(br_tid), .br_addr(br_addr),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_tid(out_tid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory: data is a function of the word address, 1-cycle latency.
  always @(posedge clk)
    imem_rdata <= imem_rd ? {16'hC0DE, 4'h0, imem_addr} : 32'hDEAD_BEEF;

  function automatic logic [31:0] instr_of(input logic [13:0] pc);
    return {16'hC0DE, 4'h0, pc[13:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

`ifndef FETCH_SKID_EN
  logic prev_rd = 1'b0;
  // Without the skid entry reads can never be issued back to back.
  always @(negedge clk) begin
    if (imem_rd) chk("rd_b2b", {31'b0, prev_rd}, 32'd0);
    prev_rd <= imem_rd;
  end
`endif

  // Two reset cycles, check reset state, release; returns at start of cycle 0.
  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; branch = 1'b0; out_ready = 1'b0;
    tick(); tick(); #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_imem_rd",   {31'b0, imem_rd},   0);
    chk("rst_ip_branch", {31'b0, ip_branch}, 0);
    chk("rst_out_pc",    {18'b0, out_pc},    0);
    chk("rst_out_instr", out_instr,          0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue n fetches (tid = k%4, pc = base + step*k); decode stalled for the
  // first 'hold' cycles. Checks every transfer in order.
  task automatic run_stream(input int n, input int hold, input int base, input int step,
                            input bit timing, input int exp_stall);
    int issued = 0, got = 0, cyc = 0, stall_rd = 0;
    logic [13:0] epc;
    while (got < n && cyc < 60) begin
      fetch_en  = (issued < n);
      tid_in    = 2'(issued);
      ins_ptr   = 14'(base + step * issued);
      out_ready = (cyc >= hold);
      #2;
      if (imem_rd) begin
        if (cyc < hold) stall_rd++;
        issued++;
      end
      if (out_valid && out_ready) begin
        epc = 14'(base + step * got);
        chk("seq_tid",   {30'b0, out_tid}, 32'(got % 4));
        chk("seq_pc",    {18'b0, out_pc},  {18'b0, epc});
        chk("seq_instr", out_instr,        instr_of(epc));
        if (timing) chk("xfer_cycle", cyc, SKID ? 2 + got : 2 + 2 * got);
        got++;
      end
      tick();
      cyc++;
    end
    chk("xfer_count", got, n);
    if (hold > 0) chk("stall_reads", stall_rd, exp_stall);
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Back-to-back stream, PCs all 0, tids 0..3.
    do_reset();
    run_stream(4, 0, 0, 0, 1'b1, 0);

    // Decode stalled 5 cycles: reads stop at capacity, order kept.
    do_reset();
    run_stream(4, 5, 8, 4, 1'b0, SKID ? 2 : 1);

    // Branch kills tid-1 fetch in flight, then redirect shown on next issue.
    do_reset();
    out_ready = 1'b1; fetch_en = 1'b1; tid_in = 2'd1; ins_ptr = 14'h20; #2;
    chk("c0_ip_branch", {31'b0, ip_branch}, 0);
    tick();
    fetch_en = 1'b0; branch = 1'b1; br_tid = 2'd1; br_addr = 14'h100;
    tick();
    branch = 1'b0; fetch_en = 1'b1; tid_in = 2'd0; ins_ptr = 14'h30; #2;
    chk("kill_out_valid", {31'b0, out_valid}, 0);
    chk("redir_ip_en",    {31'b0, ip_en},     1);
    chk("redir_branch",   {31'b0, ip_branch}, 1);
    chk("redir_tid",      {30'b0, ip_br_tid}, 1);
    chk("redir_addr",     {18'b0, ip_br_addr}, 32'h100);
    tick();
    fetch_en = 1'b0; #2;
    chk("redir_cleared",  {31'b0, ip_branch}, 0);
    chk("kill_out_valid2", {31'b0, out_valid}, 0);
    tick(); #2;
    chk("live_out_valid", {31'b0, out_valid}, 1);
    chk("live_out_tid",   {30'b0, out_tid},   0);
    chk("live_out_pc",    {18'b0, out_pc},    32'h30);
    tick();
    // Issue of tid 2 in its own branch cycle is dead.
    branch = 1'b1; br_tid = 2'd2; br_addr = 14'h200;
    fetch_en = 1'b1; tid_in = 2'd2; ins_ptr = 14'h50; #2;
    chk("dead_ip_en",     {31'b0, ip_en},     1);
    chk("dead_ip_branch", {31'b0, ip_branch}, 0);
    tick();
    branch = 1'b0; fetch_en = 1'b0;
    tick();
    fetch_en = 1'b1; tid_in = 2'd3; ins_ptr = 14'h60; #2;
    chk("dead_out_valid", {31'b0, out_valid}, 0);
    chk("redir2_ip_en",   {31'b0, ip_en},     1);
    chk("redir2_branch",  {31'b0, ip_branch}, 1);
    chk("redir2_tid",     {30'b0, ip_br_tid}, 2);
    chk("redir2_addr",    {18'b0, ip_br_addr}, 32'h200);
    tick();
    fetch_en = 1'b0; #2;
    chk("dead_out_valid2", {31'b0, out_valid}, 0);
    tick(); #2;
    chk("t3_out_valid",   {31'b0, out_valid}, 1);
    chk("t3_out_tid",     {30'b0, out_tid},   3);
    chk("t3_out_pc",      {18'b0, out_pc},    32'h60);
    tick();

    // Branch on tid 2 during a tid-2 handshake blocks the transfer.
    do_reset();
    out_ready = 1'b1; fetch_en = 1'b1; tid_in = 2'd2; ins_ptr = 14'h44;
    tick();
    fetch_en = 1'b0;
    tick(); #2;
    chk("hs_out_valid",  {31'b0, out_valid}, 1);
    chk("hs_out_tid",    {30'b0, out_tid},   2);
    branch = 1'b1; br_tid = 2'd1; br_addr = 14'h80; #1;
    chk("other_tid_keep", {31'b0, out_valid}, 1);
    br_tid = 2'd2; #1;
    chk("hs_killed",     {31'b0, out_valid}, 0);
    tick();
    branch = 1'b0; #2;
    chk("hs_gone",       {31'b0, out_valid}, 0);
    tick();

    // Reset pulse with output full (and a read in flight when skid is built).
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1; tid_in = 2'd1; ins_ptr = 14'h10;
    tick();
    tid_in = 2'd2; ins_ptr = 14'h14;
    tick();
    fetch_en = 1'b0; #2;
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    chk("pre_rst_pc",    {18'b0, out_pc},    32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0; #2;
    chk("post_rst_valid", {31'b0, out_valid}, 0);
    chk("post_rst_pc",    {18'b0, out_pc},    0);
    chk("post_rst_tid",   {30'b0, out_tid},   0);
    chk("post_rst_instr", out_instr,          0);
    tick(); #2;
    chk("post_rst_valid2", {31'b0, out_valid}, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
